// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Parametrised UART receiver. It samples an asynchronous serial line, rejects
// false start bits, and assembles frames that have a configurable data width,
// an optional odd/even parity bit and one or two stop bits. Each completed frame
// produces a one-cycle strobe. The received data and the parity/framing error
// flags are presented with that strobe.
//
// Parameters
//   CLKS_PER_BIT : i_clk cycles per serial bit (>= 4)
//   DATA_BITS    : data bits per frame (5..9)
//   PARITY       : 0 = none, 1 = odd, 2 = even
//   STOP_BITS    : stop bits expected (1 or 2)
//
// Ports
//   i_clk        : system clock
//   i_reset      : synchronous reset, active-high
//   i_rx_serial  : asynchronous serial input, idles high
//   o_rx_dv      : one-cycle strobe, frame complete
//   o_rx_byte    : received data (LSB first on the line), held until next strobe
//   o_parity_err : parity mismatch on the last frame (always 0 when PARITY=0)
//   o_frame_err  : a stop bit was sampled low on the last frame
//   o_busy       : high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_PT   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shadow;
  logic                 par_err_sh;
  logic                 frame_err_sh;
  logic                 last_stop;
  logic                 par_xor;

  // The stop sample that completes the frame is the first one for one stop
  // bit, and the second one for two stop bits.
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  // XOR of all data bits and the parity bit. It is 1 when the count of ones is odd.
  assign par_xor = (^shadow) ^ rx_s;

  // NOTE: every register in this block uses non-blocking assignments. All
  // decisions in a cycle therefore see the values from before the clock
  // edge, which is what the state/counter comparisons below rely on.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the reset is synchronous. It is sampled only on i_clk
      // edges, so a reset pulse never has to meet recovery/removal timing.
      state        <= ST_IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shadow       <= '0;
      par_err_sh   <= 1'b0;
      frame_err_sh <= 1'b0;
      o_rx_dv      <= 1'b0;
      o_rx_byte    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      // Two-flop synchroniser. Nothing downstream looks at i_rx_serial directly.
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
      o_rx_dv <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= ST_START;
            o_busy <= 1'b1;
          end
        end

        // The line is checked again at the middle of the start bit. A line
        // that is high again here was a glitch and is not a frame.
        ST_START: begin
          if (cnt == HALF_PT) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end else begin
              state        <= ST_DATA;
              bit_idx      <= '0;
              par_err_sh   <= 1'b0;
              frame_err_sh <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Samples fall one full bit period after the middle of the start bit,
        // so each one lands in the middle of a data bit. Bits shift in from
        // the top. After DATA_BITS samples, the first bit received is in bit 0.
        ST_DATA: begin
          if (cnt == SAMPLE_PT) begin
            cnt    <= '0;
            shadow <= {rx_s, shadow[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              stop_idx <= 1'b0;
              state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (cnt == SAMPLE_PT) begin
            cnt        <= '0;
            // Odd parity requires an odd count of ones across the data and
            // parity bits. Even parity requires an even count.
            par_err_sh <= (PARITY == 1) ? ~par_xor : par_xor;
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt == SAMPLE_PT) begin
            cnt <= '0;
            if (last_stop) begin
              // The frame is presented at the last stop sample. The remaining
              // half stop bit goes by in IDLE, so the next start edge is
              // seen without loss.
              o_rx_dv      <= 1'b1;
              o_rx_byte    <= shadow;
              o_parity_err <= par_err_sh;
              o_frame_err  <= frame_err_sh | ~rx_s;
              if (rx_s) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
              end else begin
                state <= ST_WAIT_HIGH;
              end
            end else begin
              frame_err_sh <= frame_err_sh | ~rx_s;
              stop_idx     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A line held low (break) produces one strobe. After that the
        // receiver waits here until the line goes high again, so the same
        // break does not start another frame.
        ST_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Four receiver instances share one clock and one reset. Each instance has its
// own serial line:
//   ch0 : 8N1
//   ch1 : 8E1 (even parity)
//   ch2 : 8O1 (odd parity)
//   ch3 : 7N2
// All instances run with CLKS_PER_BIT = 8.
// Stimulus pushes the expected frame into a per-channel queue. A monitor pops
// from that queue and compares whenever a channel raises o_rx_dv.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int CPB = 8;
  localparam int NCH = 4;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_line [NCH];

  logic       dv    [NCH];
  logic [8:0] dbyte [NCH];
  logic       perr  [NCH];
  logic       ferr  [NCH];
  logic       busy  [NCH];

  logic [7:0] b0, b1, b2;
  logic [6:0] b3;

  exp_t exp_q [NCH][$];
  int   strobe_cnt [NCH];
  int   last_cyc   [NCH];
  int   prev_cyc   [NCH];
  logic prev_dv    [NCH];
  exp_t mon_e;

  int cyc          = 0;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_reset(rst), .i_rx_serial(rx_line[0]), .o_rx_dv(dv[0]),
    .o_rx_byte(b0), .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_reset(rst), .i_rx_serial(rx_line[1]), .o_rx_dv(dv[1]),
    .o_rx_byte(b1), .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .i_clk(clk), .i_reset(rst), .i_rx_serial(rx_line[2]), .o_rx_dv(dv[2]),
    .o_rx_byte(b2), .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_busy(busy[2]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .i_clk(clk), .i_reset(rst), .i_rx_serial(rx_line[3]), .o_rx_dv(dv[3]),
    .o_rx_byte(b3), .o_parity_err(perr[3]), .o_frame_err(ferr[3]), .o_busy(busy[3]));

  assign dbyte[0] = {1'b0, b0};
  assign dbyte[1] = {1'b0, b1};
  assign dbyte[2] = {1'b0, b2};
  assign dbyte[3] = {2'b00, b3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (dv[k] === 1'b1) begin
        strobe_cnt[k]++;
        prev_cyc[k] = last_cyc[k];
        last_cyc[k] = cyc;
        check($sformatf("ch%0d_dv_one_cycle", k), {31'd0, prev_dv[k]}, 32'd0);
        if (exp_q[k].size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL ch%0d_unexpected_strobe: got data %0h, expected no strobe", k, dbyte[k]);
        end else begin
          mon_e = exp_q[k].pop_front();
          check($sformatf("ch%0d_data", k), {23'd0, dbyte[k]}, {23'd0, mon_e.data});
          check($sformatf("ch%0d_parity_err", k), {31'd0, perr[k]}, {31'd0, mon_e.perr});
          check($sformatf("ch%0d_frame_err", k), {31'd0, ferr[k]}, {31'd0, mon_e.ferr});
        end
      end
      prev_dv[k] = dv[k];
    end
  end

  task automatic expect_frame(input int ch, input logic [8:0] data, input logic pe, input logic fe);
    exp_t e;
    e.data = data;
    e.perr = pe;
    e.ferr = fe;
    exp_q[ch].push_back(e);
  endtask

  task automatic send_bit(input int ch, input logic v);
    rx_line[ch] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit,
                            input int nstop, input logic stop0, input logic stop1);
    send_bit(ch, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(ch, data[i]);
    if (has_par) send_bit(ch, par_bit);
    send_bit(ch, stop0);
    if (nstop == 2) send_bit(ch, stop1);
    rx_line[ch] = 1'b1;
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < NCH; k++) n += exp_q[k].size();
    return n;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (pending() != 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(name, pending(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  sc;
    bit  seen_busy;
    for (int k = 0; k < NCH; k++) begin
      rx_line[k]    = 1'b1;
      strobe_cnt[k] = 0;
      last_cyc[k]   = 0;
      prev_cyc[k]   = 0;
      prev_dv[k]    = 1'b0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state on every channel
    for (int k = 0; k < NCH; k++)
      check($sformatf("ch%0d_reset_outputs", k),
            {19'd0, dv[k], dbyte[k], perr[k], ferr[k], busy[k]}, 32'd0);
    repeat (2 * CPB) @(negedge clk);

    // 8N1 back-to-back 0x55 and 0xA3 with no idle gap
    expect_frame(0, 9'h055, 1'b0, 1'b0);
    expect_frame(0, 9'h0A3, 1'b0, 1'b0);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drain("b2b_drain");
    check("b2b_strobe_spacing", last_cyc[0] - prev_cyc[0], 32'd80);
    repeat (2 * CPB) @(negedge clk);

    // Two-cycle low glitch must be rejected
    sc = strobe_cnt[0];
    seen_busy = 1'b0;
    rx_line[0] = 1'b0;
    repeat (2) @(negedge clk);
    rx_line[0] = 1'b1;
    for (int n = 0; n < CPB; n++) begin
      @(negedge clk);
      if (busy[0]) seen_busy = 1'b1;
      if (seen_busy && !busy[0]) break;
    end
    check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
    check("glitch_busy_cleared", {31'd0, busy[0]}, 32'd0);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_strobe", strobe_cnt[0] - sc, 32'd0);
    expect_frame(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drain("glitch_followup_drain");

    // Parity: 0x07 has three ones
    expect_frame(1, 9'h007, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    expect_frame(1, 9'h007, 1'b1, 1'b0);
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    expect_frame(2, 9'h007, 1'b0, 1'b0);
    send_frame(2, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    expect_frame(2, 9'h007, 1'b1, 1'b0);
    send_frame(2, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    drain("parity_drain");
    repeat (2 * CPB) @(negedge clk);

    // 7N2: second stop bit low gives a framing error, then a clean frame
    expect_frame(3, 9'h041, 1'b0, 1'b1);
    send_frame(3, 9'h041, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    expect_frame(3, 9'h02A, 1'b0, 1'b0);
    send_frame(3, 9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    drain("stop2_drain");
    repeat (2 * CPB) @(negedge clk);

    // Break: 30 bit periods low gives exactly one strobe
    sc = strobe_cnt[0];
    expect_frame(0, 9'h000, 1'b0, 1'b1);
    rx_line[0] = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    check("break_busy_held", {31'd0, busy[0]}, 32'd1);
    rx_line[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_released", {31'd0, busy[0]}, 32'd0);
    check("break_single_strobe", strobe_cnt[0] - sc, 32'd1);
    drain("break_drain");
    repeat (2 * CPB) @(negedge clk);
    expect_frame(0, 9'h081, 1'b0, 1'b0);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drain("post_break_drain");
    repeat (2 * CPB) @(negedge clk);

    // Reset during data bit 4 of 0xF5 aborts the frame
    sc = strobe_cnt[0];
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    rx_line[0] = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("reset_busy_before", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs_cleared",
          {19'd0, dv[0], dbyte[0], perr[0], ferr[0], busy[0]}, 32'd0);
    repeat (6 * CPB) @(negedge clk);
    check("reset_no_strobe", strobe_cnt[0] - sc, 32'd0);
    expect_frame(0, 9'h0F0, 1'b0, 1'b0);
    send_frame(0, 9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drain("post_reset_drain");

    repeat (4 * CPB) @(negedge clk);
    check("final_queues_empty", pending(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
